// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the data bus for loads/stores,
// extracts load data and registers the MEM/WB bundle.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic        i_rd_wen,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    output logic        o_stall,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [3:0]  o_dbus_be,
    output logic [31:0] o_dbus_wdata,
    input  logic        i_dbus_gnt,
    input  logic        i_dbus_rvalid,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_sel,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_alu_result,
    output logic [31:0] o_mem_data,
    output logic        o_misalign
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        stall_q, stall_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        rdwen_q, rdwen_d;
    logic        sel_q, sel_d;
    logic        wen_q, wen_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mem_q, mem_d;
    logic        mis_q, mis_d;

    logic        is_mem, byte_op, half_op, misal;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // funct3[1:0] picks the width; unknown encodings fall through to word
    assign is_mem  = i_load | i_store;
    assign byte_op = (i_funct3[1:0] == 2'b00);
    assign half_op = (i_funct3[1:0] == 2'b01);
    assign misal   = half_op ? i_alu_result[0]
                   : (!byte_op && (i_alu_result[1:0] != 2'b00));

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = i_store_data;
        if (byte_op) begin
            be_in    = 4'b0001 << i_alu_result[1:0];
            wdata_in = {4{i_store_data[7:0]}};
        end else if (half_op) begin
            be_in    = i_alu_result[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{i_store_data[15:0]}};
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = i_dbus_rdata[7:0];
            2'd1:    ld_byte = i_dbus_rdata[15:8];
            2'd2:    ld_byte = i_dbus_rdata[23:16];
            default: ld_byte = i_dbus_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
        if (f3_q[1:0] == 2'b00)
            ld_ext = f3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        else if (f3_q[1:0] == 2'b01)
            ld_ext = f3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        else
            ld_ext = i_dbus_rdata;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        rdwen_d = rdwen_q;
        sel_d   = sel_q;
        wen_d   = 1'b0;
        wbrd_d  = wbrd_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (!is_mem) begin
                        sel_d  = 1'b1;
                        wen_d  = i_rd_wen;
                        wbrd_d = i_rd_addr;
                        alu_d  = i_alu_result;
                    end else if (misal) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = !i_load;
                        addr_d  = i_alu_result;
                        be_d    = be_in;
                        wdata_d = wdata_in;
                        f3_d    = i_funct3;
                        rd_d    = i_rd_addr;
                        rdwen_d = i_rd_wen;
                    end
                end
            end
            REQ: begin
                if (i_dbus_gnt) begin
                    req_d   = 1'b0;
                    state_d = we_q ? IDLE : RESP;
                end
            end
            RESP: begin
                if (i_dbus_rvalid) begin
                    state_d = IDLE;
                    mem_d   = ld_ext;
                    sel_d   = 1'b0;
                    wen_d   = rdwen_q;
                    wbrd_d  = rd_q;
                    alu_d   = addr_q;
                end
            end
            default: state_d = IDLE;
        endcase
        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rd_q    <= 5'd0;
            rdwen_q <= 1'b0;
            sel_q   <= 1'b0;
            wen_q   <= 1'b0;
            wbrd_q  <= 5'd0;
            alu_q   <= 32'd0;
            mem_q   <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            rdwen_q <= rdwen_d;
            sel_q   <= sel_d;
            wen_q   <= wen_d;
            wbrd_q  <= wbrd_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            mis_q   <= mis_d;
        end
    end

    assign o_stall      = stall_q;
    assign o_dbus_req   = req_q;
    assign o_dbus_we    = we_q;
    assign o_dbus_addr  = {addr_q[31:2], 2'b00};
    assign o_dbus_be    = be_q;
    assign o_dbus_wdata = wdata_q;
    assign o_sel        = sel_q;
    assign o_rd_wen     = wen_q;
    assign o_rd_addr    = wbrd_q;
    assign o_alu_result = alu_q;
    assign o_mem_data   = mem_q;
    assign o_misalign   = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table driven through a bus responder,
// writebacks checked in program order against a scoreboard queue.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_load, i_store, i_rd_wen;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_alu_result, i_store_data;
    logic        o_stall, o_dbus_req, o_dbus_we;
    logic [31:0] o_dbus_addr, o_dbus_wdata;
    logic [3:0]  o_dbus_be;
    logic        i_dbus_gnt, i_dbus_rvalid;
    logic [31:0] i_dbus_rdata;
    logic        o_sel, o_rd_wen, o_misalign;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_alu_result, o_mem_data;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_load(i_load), .i_store(i_store),
        .i_funct3(i_funct3), .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr),
        .i_alu_result(i_alu_result), .i_store_data(i_store_data),
        .o_stall(o_stall), .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we),
        .o_dbus_addr(o_dbus_addr), .o_dbus_be(o_dbus_be),
        .o_dbus_wdata(o_dbus_wdata), .i_dbus_gnt(i_dbus_gnt),
        .i_dbus_rvalid(i_dbus_rvalid), .i_dbus_rdata(i_dbus_rdata),
        .o_sel(o_sel), .o_rd_wen(o_rd_wen), .o_rd_addr(o_rd_addr),
        .o_alu_result(o_alu_result), .o_mem_data(o_mem_data),
        .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          gw;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        logic [31:0] daddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mem;
    } vec_t;

    typedef struct {
        logic        sel;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
    } wb_t;

    wb_t sb[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && o_rd_wen === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_wb: rd_addr %0d written, none expected",
                         o_rd_addr);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_sel", 32'(o_sel), 32'(e.sel));
                chk("wb_rd", 32'(o_rd_addr), 32'(e.rd));
                chk("wb_alu", o_alu_result, e.alu);
                if (!e.sel) chk("wb_mem", o_mem_data, e.mem);
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        logic is_mem;
        is_mem       = v.ld | v.st;
        i_valid      = 1'b1;
        i_load       = v.ld;
        i_store      = v.st;
        i_funct3     = v.f3;
        i_alu_result = v.addr;
        i_store_data = v.rs2;
        i_rd_wen     = v.wen;
        i_rd_addr    = v.rd;
        if (!is_mem && v.wen) sb.push_back('{1'b1, v.rd, v.addr, 32'd0});
        if (is_mem && !v.mis && v.ld && v.wen)
            sb.push_back('{1'b0, v.rd, v.addr, v.mem});
        @(negedge clk);
        i_valid = 1'b0;
        if (v.mis) begin
            chk($sformatf("v%0d_mis", idx), 32'(o_misalign), 32'd1);
            chk($sformatf("v%0d_mis_req", idx), 32'(o_dbus_req), 32'd0);
            chk($sformatf("v%0d_mis_stall", idx), 32'(o_stall), 32'd0);
            chk($sformatf("v%0d_mis_wen", idx), 32'(o_rd_wen), 32'd0);
            i_dbus_gnt    = 1'b1;
            i_dbus_rvalid = 1'b1;
            @(negedge clk);
            i_dbus_gnt    = 1'b0;
            i_dbus_rvalid = 1'b0;
            chk($sformatf("v%0d_mis_pulse", idx), 32'(o_misalign), 32'd0);
            chk($sformatf("v%0d_stray_req", idx), 32'(o_dbus_req), 32'd0);
        end else if (!is_mem) begin
            chk($sformatf("v%0d_alu_stall", idx), 32'(o_stall), 32'd0);
            chk($sformatf("v%0d_alu_wen", idx), 32'(o_rd_wen), 32'(v.wen));
        end else begin
            chk($sformatf("v%0d_stall", idx), 32'(o_stall), 32'd1);
            chk($sformatf("v%0d_req", idx), 32'(o_dbus_req), 32'd1);
            chk($sformatf("v%0d_daddr", idx), o_dbus_addr, v.daddr);
            chk($sformatf("v%0d_we", idx), 32'(o_dbus_we), 32'(!v.ld));
            if (!v.ld) begin
                chk($sformatf("v%0d_be", idx), 32'(o_dbus_be), 32'(v.be));
                chk($sformatf("v%0d_wdata", idx), o_dbus_wdata, v.wdata);
            end
            for (int k = 0; k < v.gw; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_addr_hold", idx), o_dbus_addr, v.daddr);
                chk($sformatf("v%0d_req_hold", idx), 32'(o_dbus_req), 32'd1);
            end
            i_dbus_gnt = 1'b1;
            @(negedge clk);
            i_dbus_gnt = 1'b0;
            if (!v.ld) begin
                chk($sformatf("v%0d_st_stall", idx), 32'(o_stall), 32'd0);
                chk($sformatf("v%0d_st_req", idx), 32'(o_dbus_req), 32'd0);
                chk($sformatf("v%0d_st_wen", idx), 32'(o_rd_wen), 32'd0);
            end else begin
                chk($sformatf("v%0d_resp_stall", idx), 32'(o_stall), 32'd1);
                chk($sformatf("v%0d_resp_req", idx), 32'(o_dbus_req), 32'd0);
                i_dbus_rvalid = 1'b1;
                i_dbus_rdata  = v.rdata;
                @(negedge clk);
                i_dbus_rvalid = 1'b0;
                i_dbus_rdata  = $urandom;
                chk($sformatf("v%0d_ld_stall", idx), 32'(o_stall), 32'd0);
            end
        end
        #1;
        chk($sformatf("v%0d_sb_drained", idx), 32'(sb.size()), 32'd0);
    endtask

    vec_t vt[21];

    initial begin
        vt[0]  = '{1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 0, 5'd5, 1'b1,
                   1'b0, 32'h0, 4'h0, 32'h0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FFFFFF, 2, 5'd7,
                   1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, 32'hFFFFFF80};
        vt[2]  = '{1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FFFFFF, 2, 5'd8,
                   1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, 32'h00000080};
        vt[3]  = '{1'b0, 1'b1, 3'b001, 32'h2002, 32'hABCD1234, 32'h0, 0, 5'd0,
                   1'b0, 1'b0, 32'h2000, 4'b1100, 32'h12341234, 32'h0};
        vt[4]  = '{1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 5'd6, 1'b1,
                   1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 3'b001, 32'h4002, 32'h0, 32'h80017FFF, 1, 5'd9,
                   1'b1, 1'b0, 32'h4000, 4'h0, 32'h0, 32'hFFFF8001};
        vt[6]  = '{1'b1, 1'b0, 3'b101, 32'h4000, 32'h0, 32'h8001F00F, 0, 5'd12,
                   1'b1, 1'b0, 32'h4000, 4'h0, 32'h0, 32'h0000F00F};
        vt[7]  = '{1'b1, 1'b0, 3'b010, 32'h5004, 32'h0, 32'hDEADBEEF, 1, 5'd13,
                   1'b1, 1'b0, 32'h5004, 4'h0, 32'h0, 32'hDEADBEEF};
        vt[8]  = '{1'b0, 1'b1, 3'b000, 32'h6001, 32'h000000A5, 32'h0, 1, 5'd2,
                   1'b1, 1'b0, 32'h6000, 4'b0010, 32'hA5A5A5A5, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 3'b010, 32'h7000, 32'hCAFEF00D, 32'h0, 3, 5'd0,
                   1'b0, 1'b0, 32'h7000, 4'b1111, 32'hCAFEF00D, 32'h0};
        vt[10] = '{1'b0, 1'b1, 3'b001, 32'h7001, 32'h1, 32'h0, 0, 5'd0, 1'b0,
                   1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vt[11] = '{1'b1, 1'b0, 3'b000, 32'h8000, 32'h0, 32'h1234567F, 0, 5'd14,
                   1'b1, 1'b0, 32'h8000, 4'h0, 32'h0, 32'h0000007F};
        vt[12] = '{1'b1, 1'b0, 3'b000, 32'h8002, 32'h0, 32'h12B45678, 0, 5'd14,
                   1'b1, 1'b0, 32'h8000, 4'h0, 32'h0, 32'hFFFFFFB4};
        vt[13] = '{1'b1, 1'b1, 3'b010, 32'h9000, 32'h0, 32'h11223344, 1, 5'd15,
                   1'b1, 1'b0, 32'h9000, 4'h0, 32'h0, 32'h11223344};
        vt[14] = '{1'b1, 1'b0, 3'b011, 32'h9008, 32'h0, 32'h55667788, 0, 5'd16,
                   1'b1, 1'b0, 32'h9008, 4'h0, 32'h0, 32'h55667788};
        vt[15] = '{1'b1, 1'b0, 3'b111, 32'h9002, 32'h0, 32'h0, 0, 5'd17, 1'b1,
                   1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vt[16] = '{1'b1, 1'b0, 3'b001, 32'h4001, 32'h0, 32'h0, 0, 5'd18, 1'b1,
                   1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
        vt[17] = '{1'b0, 1'b0, 3'b000, 32'hBEEF, 32'h0, 32'h0, 0, 5'd9, 1'b0,
                   1'b0, 32'h0, 4'h0, 32'h0, 32'h0};
        vt[18] = '{1'b0, 1'b1, 3'b001, 32'h2000, 32'h0000BEEF, 32'h0, 0, 5'd0,
                   1'b0, 1'b0, 32'h2000, 4'b0011, 32'hBEEFBEEF, 32'h0};
        vt[19] = '{1'b0, 1'b1, 3'b000, 32'h6003, 32'h0000005A, 32'h0, 2, 5'd0,
                   1'b0, 1'b0, 32'h6000, 4'b1000, 32'h5A5A5A5A, 32'h0};
        vt[20] = '{1'b1, 1'b0, 3'b101, 32'h4002, 32'h0, 32'h80017FFF, 0, 5'd19,
                   1'b1, 1'b0, 32'h4000, 4'h0, 32'h0, 32'h00008001};

        rst = 1'b1;
        i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_funct3 = 3'd0;
        i_rd_wen = 1'b0; i_rd_addr = 5'd0; i_alu_result = 32'd0;
        i_store_data = 32'd0; i_dbus_gnt = 1'b0; i_dbus_rvalid = 1'b0;
        i_dbus_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_req", 32'(o_dbus_req), 32'd0);
        chk("rst_wen", 32'(o_rd_wen), 32'd0);
        chk("rst_misalign", 32'(o_misalign), 32'd0);
        chk("rst_alu", o_alu_result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) run_vec(vt[i], i);

        // reset while waiting for a load response
        @(negedge clk);
        i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b010;
        i_alu_result = 32'h100; i_rd_addr = 5'd4; i_rd_wen = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_dbus_gnt = 1'b1;
        @(negedge clk);
        i_dbus_gnt = 1'b0;
        chk("rstmid_resp_stall", 32'(o_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_stall", 32'(o_stall), 32'd0);
        chk("rstmid_req", 32'(o_dbus_req), 32'd0);
        chk("rstmid_addr", o_dbus_addr, 32'd0);
        chk("rstmid_be", 32'(o_dbus_be), 32'd0);
        chk("rstmid_wdata", o_dbus_wdata, 32'd0);
        chk("rstmid_alu", o_alu_result, 32'd0);
        chk("rstmid_mem", o_mem_data, 32'd0);
        chk("rstmid_rd", 32'(o_rd_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        i_dbus_rvalid = 1'b1;
        i_dbus_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        i_dbus_rvalid = 1'b0;
        chk("late_rvalid_wen", 32'(o_rd_wen), 32'd0);
        chk("late_rvalid_stall", 32'(o_stall), 32'd0);
        chk("late_rvalid_mem", o_mem_data, 32'd0);

        // load then ALU op held at the inputs under stall
        sb.push_back('{1'b0, 5'd10, 32'h4002, 32'hFFFF8001});
        sb.push_back('{1'b1, 5'd11, 32'h77, 32'h0});
        i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b001;
        i_alu_result = 32'h4002; i_rd_addr = 5'd10; i_rd_wen = 1'b1;
        @(negedge clk);
        i_load = 1'b0; i_alu_result = 32'h77; i_rd_addr = 5'd11;
        chk("hold_stall", 32'(o_stall), 32'd1);
        i_dbus_gnt = 1'b1;
        @(negedge clk);
        i_dbus_gnt = 1'b0;
        chk("hold_resp_stall", 32'(o_stall), 32'd1);
        chk("hold_no_early_wb", 32'(o_rd_wen), 32'd0);
        i_dbus_rvalid = 1'b1;
        i_dbus_rdata  = 32'h80017FFF;
        @(negedge clk);
        i_dbus_rvalid = 1'b0;
        chk("hold_release", 32'(o_stall), 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        chk("hold_alu_stall", 32'(o_stall), 32'd0);
        #1;
        chk("hold_sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline. It sits between execute and writeback. It performs LB/LH/LW/LBU/LHU/SB/SH/SW over a request/grant/response data bus, and extracts and sign-extends load data. It registers the result into the MEM/WB pipeline register that drives the writeback mux inputs (sel, rd_wen, rd_addr, alu_result, mem_data). While a bus transaction is outstanding it stalls upstream.

## Interface
- No parameters. Data and address are fixed at 32 bits; addressing is by byte.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  EX→MEM instruction valid
- i_load / i_store  in  1  memory op type; if both are high, the op is treated as a load
- i_funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
  - Any other encoding is treated as W.
- i_rd_wen  in  1  destination write enable
- i_rd_addr  in  5  destination register
- i_alu_result  in  32  ALU result; this is also the effective address for memory ops
- i_store_data  in  32  rs2 value for stores
- o_stall  out  1  registered; high means upstream must hold; i_* are ignored while high
- o_dbus_req  out  1  bus request
- o_dbus_we  out  1  1 = store
- o_dbus_addr  out  32  {addr[31:2], 2'b00}
- o_dbus_be  out  4  byte enables
- o_dbus_wdata  out  32  lane-replicated store data
- i_dbus_gnt  in  1  request accepted this cycle
- i_dbus_rvalid  in  1  read data valid
- i_dbus_rdata  in  32  read word
- o_sel  out  1  1 = ALU result, 0 = memory data
- o_rd_wen  out  1  MEM/WB write enable
- o_rd_addr  out  5  MEM/WB destination register
- o_alu_result  out  32  MEM/WB ALU result
- o_mem_data  out  32  MEM/WB extended load data
- o_misalign  out  1  one-cycle pulse when a misaligned access is dropped

## Operation
- FSM has three states: IDLE, REQ, RESP. All outputs and all state are registered.
- **IDLE**, sampling i_* each cycle:
  - i_valid=0: emit a bubble (o_rd_wen=0; other MEM/WB fields hold).
  - Valid non-memory op: o_sel=1; o_rd_wen, o_rd_addr, o_alu_result are copied from the inputs.
  - Valid aligned memory op: capture addr, funct3, rd, store data; emit a bubble; go to REQ.
  - Valid misaligned memory op: no bus request; o_misalign=1 next cycle; o_rd_wen=0; stay in IDLE.
    - H/HU/SH is misaligned when addr[0]=1.
    - W/SW is misaligned when addr[1:0]≠0.
- **REQ**:
  - o_dbus_req=1; addr, we, be, wdata stay stable until i_dbus_gnt.
  - On gnt with a store: complete, emitting MEM/WB rd_wen=0; go to IDLE.
  - On gnt with a load: go to RESP.
- **RESP**:
  - Wait for i_dbus_rvalid, then register o_mem_data, o_sel=0, o_rd_wen=captured rd_wen, o_rd_addr, o_alu_result=address; go to IDLE.
- Byte enables and store data:
  - SB: be = 1<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111; wdata = rs2.
- Load extraction:
  - The byte lane is selected by addr[1:0]; the halfword lane by addr[1].
  - B/H are sign-extended; BU/HU are zero-extended; W passes through unchanged.
- Stall and bubbles:
  - o_stall = (next state ≠ IDLE), registered.
  - Every cycle that is not a completion emits o_rd_wen=0.
- Stray responses: i_dbus_rvalid outside RESP is ignored, as is i_dbus_gnt outside REQ.

## Timing
- Reset values while rst is high, taking effect immediately:
  - state IDLE
  - all outputs 0, including o_dbus_req=0 and o_stall=0
- Reset mid-transaction abandons the access. A late rvalid after reset is ignored.
- Non-memory op: accepted at edge T; MEM/WB outputs valid after edge T.
- Store timeline:
  - Accepted at T; req is high from T+1.
  - If gnt arrives in cycle T+1+k, the completion bubble appears after edge T+2+k and o_stall falls at the same edge.
- Load timeline:
  - gnt arrives in cycle G; rvalid arrives in cycle R, where R≥G+1 is a bus guarantee.
  - Outputs are valid after edge R+1.
  - Minimum load latency is 3 cycles from acceptance.
- o_stall is high from the edge after acceptance through the completion edge. Upstream advances on the first cycle with o_stall=0.
- Back-to-back ops: a new op can be accepted in the first IDLE cycle, i.e. the cycle in which completion results are visible.

## Test plan
- ALU op: i_valid=1, load=store=0, alu_result=0x1234, rd=5, rd_wen=1 → next cycle sel=1, rd_wen=1, rd_addr=5, alu_result=0x1234, stall=0.
- LB at 0x1003 with rdata=0x80FFFFFF, gnt after 2 wait cycles, rvalid 1 cycle later:
  - dbus_addr=0x1000 held stable throughout the wait.
  - mem_data=0xFFFFFF80, sel=0.
  - Same access as LBU gives mem_data=0x80.
- SH at 0x2002 with rs2=0xABCD1234, gnt immediate → be=1100, wdata=0x12341234, we=1; completion with rd_wen=0; stall high for exactly 1 cycle.
- LW at 0x3001 → no req, misalign pulse for 1 cycle, rd_wen=0, stall=0.
- rst asserted in RESP, then rvalid pulsed → outputs 0, state IDLE, rvalid ignored, no writeback.
- Load immediately followed by an ALU op held under stall → the ALU op is accepted on the cycle stall falls; writebacks occur in program order.
